// File: rtl/calc_pkg.sv
// calc_pkg: shared state encodings, operator codes and default width for the
// calculator sequencer and its divider.
package calc_pkg;

  localparam int CALC_WIDTH = 8;

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_OP   = 3'd1,
    S_B    = 3'd2,
    S_EXEC = 3'd3,
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } op_e;

endpackage

// File: rtl/calc_div.sv
// calc_div: restoring iterative divider, one quotient bit per cycle.
// start loads the operands; WIDTH iterations later done pulses for one cycle.
// abort cancels an in-flight division. Divisor is assumed non-zero by caller.
module calc_div
  import calc_pkg::*;
#(
  parameter int WIDTH = CALC_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             act_q, act_d, done_q, done_d;
  logic [WIDTH:0]   shifted, diff;

  // One restoring step: shift next dividend bit into the partial remainder,
  // keep the trial subtraction only when it does not go negative.
  always_comb begin
    shifted = {rem_q, quo_q[WIDTH-1]};
    diff    = shifted - {1'b0, dvs_q};
    quo_d   = quo_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    act_d   = act_q;
    done_d  = 1'b0;
    if (abort) begin
      act_d = 1'b0;
    end else if (start) begin
      act_d = 1'b1;
      cnt_d = '0;
      quo_d = dividend;
      rem_d = '0;
      dvs_d = divisor;
    end else if (act_q) begin
      quo_d = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
      rem_d = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CW'(WIDTH - 1)) begin
        act_d  = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  // Divider state registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      quo_q  <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      act_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      dvs_q  <= dvs_d;
      cnt_q  <= cnt_d;
      act_q  <= act_d;
      done_q <= done_d;
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign done      = done_q;

endmodule

// File: rtl/calc_seq.sv
// calc_seq: calculator operation sequencer (A -> op -> B -> exec -> done).
// Optional divider enabled by defining CALC_DIV_EN; without it op 11 always
// lands in ERR. All outputs are registered.
module calc_seq
  import calc_pkg::*;
#(
  parameter int WIDTH = CALC_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   sw,
  input  logic               key_ld,
  input  logic               key_op,
  input  logic               key_clr,
  input  logic [1:0]         op_sel,
  output logic [2*WIDTH-1:0] result,
  output logic               valid,
  output logic               busy,
  output logic               err,
  output logic [2:0]         state
);

  state_e             state_q, state_d;
  op_e                op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [2*WIDTH-1:0] result_q, result_d, alu_res;
  logic               valid_q, valid_d, busy_q, busy_d, err_q, err_d;
  logic [WIDTH:0]     sum_w, diff_w;
  logic [2*WIDTH-1:0] prod_w;
  logic               div_start, div_done;
  logic [WIDTH-1:0]   div_quo, div_rem;

`ifdef CALC_DIV_EN
  calc_div #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .abort     (key_clr),
    .dividend  (a_q),
    .divisor   (sw),
    .quotient  (div_quo),
    .remainder (div_rem),
    .done      (div_done)
  );
`else
  assign div_done = 1'b0;
  assign div_quo  = '0;
  assign div_rem  = '0;
`endif

  // Single-cycle ALU for add/sub/mul on the latched operands.
  always_comb begin
    sum_w  = {1'b0, a_q} + {1'b0, b_q};
    diff_w = {1'b0, a_q} - {1'b0, b_q};
    prod_w = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
    case (op_q)
      OP_ADD:  alu_res = {{(WIDTH-1){1'b0}}, sum_w};
      OP_SUB:  alu_res = {{(WIDTH-1){diff_w[WIDTH]}}, diff_w};
      OP_MUL:  alu_res = prod_w;
      default: alu_res = '0;
    endcase
  end

  // Next-state and register-update logic; key_clr overrides every state.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    result_d  = result_q;
    div_start = 1'b0;
    if (key_clr) begin
      state_d  = S_A;
      result_d = '0;
    end else begin
      case (state_q)
        S_A: if (key_ld) begin
          a_d     = sw;
          state_d = S_OP;
        end
        S_OP: if (key_op) begin
          op_d    = op_e'(op_sel);
          state_d = S_B;
        end else if (key_ld) begin
          a_d = sw;
        end
        S_B: if (key_ld) begin
          b_d = sw;
          if (op_q == OP_DIV) begin
`ifdef CALC_DIV_EN
            if (sw == '0) begin
              state_d = S_ERR;
            end else begin
              div_start = 1'b1;
              state_d   = S_EXEC;
            end
`else
            state_d = S_ERR;
`endif
          end else begin
            state_d = S_EXEC;
          end
        end
        S_EXEC: if (op_q != OP_DIV) begin
          result_d = alu_res;
          state_d  = S_DONE;
        end else if (div_done) begin
          result_d = {div_rem, div_quo};
          state_d  = S_DONE;
        end
        S_DONE: if (key_op) begin
          a_d     = result_q[WIDTH-1:0];
          op_d    = op_e'(op_sel);
          state_d = S_B;
        end else if (key_ld) begin
          a_d     = sw;
          state_d = S_OP;
        end
        S_ERR: ;
        default: state_d = S_A;
      endcase
    end
    valid_d = (state_d == S_DONE);
    busy_d  = (state_d == S_EXEC);
    err_d   = (state_d == S_ERR);
  end

  // Sequencer registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_A;
      op_q     <= OP_ADD;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
    end
  end

  assign result = result_q;
  assign valid  = valid_q;
  assign busy   = busy_q;
  assign err    = err_q;
  assign state  = state_q;

endmodule

// File: tb/tb_calc_seq.sv
// tb_calc_seq: directed self-checking bench for calc_seq. Observed word is
// {state, valid, busy, err, result}.
module tb_calc_seq;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [W-1:0]   sw;
  logic           key_ld, key_op, key_clr;
  logic [1:0]     op_sel;
  logic [2*W-1:0] result;
  logic           valid, busy, err;
  logic [2:0]     state;

  int n_chk  = 0;
  int n_fail = 0;

  calc_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .sw(sw), .key_ld(key_ld), .key_op(key_op),
    .key_clr(key_clr), .op_sel(op_sel), .result(result), .valid(valid),
    .busy(busy), .err(err), .state(state)
  );

  always #5 clk = ~clk;

  wire [21:0] obs = {state, valid, busy, err, result};

  task automatic press(input logic ld, input logic op, input logic clr,
                       input logic [W-1:0] v, input logic [1:0] o);
    @(negedge clk);
    sw = v; op_sel = o; key_ld = ld; key_op = op; key_clr = clr;
    @(negedge clk);
    key_ld = 1'b0; key_op = 1'b0; key_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; sw = '0; key_ld = 0; key_op = 0; key_clr = 0; op_sel = 2'b00;
    repeat (3) @(negedge clk);
    n_chk++;
    if (obs !== {3'd0, 3'b000, 16'h0000}) begin
      n_fail++; $display("FAIL reset: got %h exp %h", obs, {3'd0, 3'b000, 16'h0000});
    end
    rst = 1'b1;
  endtask

  task automatic test_add();
    press(0, 1, 0, 8'd0, 2'b00);  // key_op in A ignored
    n_chk++;
    if (state !== 3'd0) begin n_fail++; $display("FAIL op_in_a: got %0d exp 0", state); end
    press(1, 0, 0, 8'd1, 2'b00);
    press(1, 0, 0, 8'd12, 2'b00); // overwrite A in OP
    n_chk++;
    if (state !== 3'd1) begin n_fail++; $display("FAIL add_op_state: got %0d exp 1", state); end
    press(0, 1, 0, 8'd0, 2'b00);
    n_chk++;
    if (state !== 3'd2) begin n_fail++; $display("FAIL add_b_state: got %0d exp 2", state); end
    press(1, 0, 0, 8'd30, 2'b00);
    n_chk++;
    if (obs[21:16] !== {3'd3, 3'b010}) begin
      n_fail++; $display("FAIL add_exec: got %h exp %h", obs[21:16], {3'd3, 3'b010});
    end
    @(negedge clk);
    n_chk++;
    if (obs !== {3'd4, 3'b100, 16'd42}) begin
      n_fail++; $display("FAIL add_done: got %h exp %h", obs, {3'd4, 3'b100, 16'd42});
    end
  endtask

  task automatic test_sub_chain();
    press(1, 0, 0, 8'd5, 2'b00);
    press(0, 1, 0, 8'd0, 2'b01);
    press(1, 0, 0, 8'd9, 2'b00);
    @(negedge clk);
    n_chk++;
    if (obs !== {3'd4, 3'b100, 16'hFFFC}) begin
      n_fail++; $display("FAIL sub_neg: got %h exp %h", obs, {3'd4, 3'b100, 16'hFFFC});
    end
    press(0, 1, 0, 8'd0, 2'b01);
    n_chk++;
    if (obs !== {3'd2, 3'b000, 16'hFFFC}) begin
      n_fail++; $display("FAIL chain_state: got %h exp %h", obs, {3'd2, 3'b000, 16'hFFFC});
    end
    press(1, 0, 0, 8'd2, 2'b00);
    @(negedge clk);
    n_chk++;
    if (obs !== {3'd4, 3'b100, 16'h00FA}) begin
      n_fail++; $display("FAIL sub_chain: got %h exp %h", obs, {3'd4, 3'b100, 16'h00FA});
    end
  endtask

  task automatic test_mul_both_keys();
    press(1, 0, 0, 8'd200, 2'b00);
    press(0, 1, 0, 8'd0, 2'b10);
    press(1, 0, 0, 8'd200, 2'b00);
    @(negedge clk);
    n_chk++;
    if (obs !== {3'd4, 3'b100, 16'h9C40}) begin
      n_fail++; $display("FAIL mul: got %h exp %h", obs, {3'd4, 3'b100, 16'h9C40});
    end
    press(1, 1, 0, 8'd77, 2'b00); // key_op wins: chain with A=0x40, op add
    n_chk++;
    if (state !== 3'd2) begin n_fail++; $display("FAIL both_keys: got %0d exp 2", state); end
    press(1, 0, 0, 8'd1, 2'b00);
    @(negedge clk);
    n_chk++;
    if (result !== 16'h0041) begin n_fail++; $display("FAIL chain_a: got %h exp 0041", result); end
  endtask

  task automatic test_div();
    int busy_cnt;
    int waited;
    press(1, 0, 0, 8'd100, 2'b00);
    press(0, 1, 0, 8'd0, 2'b11);
    press(1, 0, 0, 8'd7, 2'b00);
`ifdef CALC_DIV_EN
    busy_cnt = 0; waited = 0;
    while (!valid && waited < 30) begin
      if (busy) busy_cnt++;
      waited++;
      @(negedge clk);
    end
    n_chk++;
    if (busy_cnt !== 9 || waited !== 9) begin
      n_fail++; $display("FAIL div_timing: got busy %0d wait %0d exp 9 9", busy_cnt, waited);
    end
    n_chk++;
    if (obs !== {3'd4, 3'b100, 16'h020E}) begin
      n_fail++; $display("FAIL div_result: got %h exp %h", obs, {3'd4, 3'b100, 16'h020E});
    end
`else
    busy_cnt = 0; waited = 0;
    n_chk++;
    if (obs[21:16] !== {3'd5, 3'b001}) begin
      n_fail++; $display("FAIL div_disabled: got %h exp %h", obs[21:16], {3'd5, 3'b001});
    end
    press(0, 0, 1, 8'd0, 2'b00);
`endif
  endtask

  task automatic test_div_zero();
    press(0, 0, 1, 8'd0, 2'b00);
    press(1, 0, 0, 8'd3, 2'b00);
    press(0, 1, 0, 8'd0, 2'b00);
    press(1, 0, 0, 8'd4, 2'b00);
    @(negedge clk);
    press(1, 0, 0, 8'd9, 2'b00);
    press(0, 1, 0, 8'd0, 2'b11);
    press(1, 0, 0, 8'd0, 2'b00);
    n_chk++;
    if (obs !== {3'd5, 3'b001, 16'd7}) begin
      n_fail++; $display("FAIL div_zero: got %h exp %h", obs, {3'd5, 3'b001, 16'd7});
    end
    press(1, 0, 0, 8'd5, 2'b00);
    press(0, 1, 0, 8'd0, 2'b00);
    n_chk++;
    if (obs !== {3'd5, 3'b001, 16'd7}) begin
      n_fail++; $display("FAIL err_sticky: got %h exp %h", obs, {3'd5, 3'b001, 16'd7});
    end
    press(0, 0, 1, 8'd0, 2'b00);
    n_chk++;
    if (obs !== {3'd0, 3'b000, 16'd0}) begin
      n_fail++; $display("FAIL err_clr: got %h exp %h", obs, {3'd0, 3'b000, 16'd0});
    end
  endtask

  task automatic test_clr_mid_div();
    press(1, 0, 0, 8'd100, 2'b00);
    press(0, 1, 0, 8'd0, 2'b11);
    press(1, 0, 0, 8'd7, 2'b00);
    repeat (2) @(negedge clk);
`ifdef CALC_DIV_EN
    n_chk++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL div_busy_mid: got %b exp 1", busy); end
`endif
    press(0, 0, 1, 8'd0, 2'b00);
    n_chk++;
    if (obs !== {3'd0, 3'b000, 16'd0}) begin
      n_fail++; $display("FAIL clr_mid_div: got %h exp %h", obs, {3'd0, 3'b000, 16'd0});
    end
`ifdef CALC_DIV_EN
    press(1, 0, 0, 8'd50, 2'b00);
    press(0, 1, 0, 8'd0, 2'b11);
    press(1, 0, 0, 8'd5, 2'b00);
    repeat (9) @(negedge clk);
    n_chk++;
    if (obs !== {3'd4, 3'b100, 16'h000A}) begin
      n_fail++; $display("FAIL div_after_abort: got %h exp %h", obs, {3'd4, 3'b100, 16'h000A});
    end
`endif
  endtask

  task automatic test_reset_in_done();
    press(1, 0, 0, 8'd3, 2'b00);
    press(0, 1, 0, 8'd0, 2'b10);
    press(1, 0, 0, 8'd4, 2'b00);
    @(negedge clk);
    n_chk++;
    if (obs !== {3'd4, 3'b100, 16'd12}) begin
      n_fail++; $display("FAIL pre_reset: got %h exp %h", obs, {3'd4, 3'b100, 16'd12});
    end
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    n_chk++;
    if (obs !== {3'd0, 3'b000, 16'd0}) begin
      n_fail++; $display("FAIL reset_in_done: got %h exp %h", obs, {3'd0, 3'b000, 16'd0});
    end
    // Operands were cleared: chaining 0 + 5 must give 5
    press(1, 0, 0, 8'd0, 2'b00);
    press(0, 1, 0, 8'd0, 2'b00);
    press(1, 0, 0, 8'd5, 2'b00);
    @(negedge clk);
    n_chk++;
    if (result !== 16'd5) begin n_fail++; $display("FAIL post_reset_add: got %h exp 0005", result); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_chain();
    test_mul_both_keys();
    test_div();
    test_div_zero();
    test_clr_mid_div();
    test_reset_in_done();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
